// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential binary32 multiplier with shift-add mantissa loop and valid/ready handshakes
module fp_mul_seq #(
  parameter int MANT_W = 24,
  parameter int BIAS   = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid,
  output logic        busy
);
  localparam int CW = $clog2(MANT_W);
  typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;
  state_t r_state, w_next;
  logic               r_sign, r_ovf, r_unf, r_inv;
  logic signed [9:0]  r_exp;
  logic [MANT_W-1:0]  r_mcand, r_mplier, r_acc;
  logic [CW-1:0]      r_cnt;
  logic [31:0]        r_result;
  logic [7:0]         w_ea, w_eb;
  logic               w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_sign, w_special, w_inv, w_accept, w_last;
  logic [31:0]        w_spec_res, w_norm_res;
  logic signed [9:0]  w_exp, w_en;
  logic [MANT_W:0]    w_sum;
  logic [2*MANT_W-1:0] w_prod;
  logic [22:0]        w_frac;
  logic               w_ovf, w_unf;
  assign w_ea       = A[30:23];
  assign w_eb       = B[30:23];
  assign w_za       = w_ea == 8'h00;
  assign w_zb       = w_eb == 8'h00;
  assign w_ia       = w_ea == 8'hFF && A[22:0] == 23'd0;
  assign w_ib       = w_eb == 8'hFF && B[22:0] == 23'd0;
  assign w_na       = w_ea == 8'hFF && A[22:0] != 23'd0;
  assign w_nb       = w_eb == 8'hFF && B[22:0] != 23'd0;
  assign w_sign     = A[31] ^ B[31];
  assign w_special  = w_za | w_zb | (w_ea == 8'hFF) | (w_eb == 8'hFF);
  assign w_inv      = w_na | w_nb | (w_ia & w_zb) | (w_za & w_ib);
  assign w_spec_res = w_inv ? 32'h7FC00000 : (w_ia | w_ib) ? {w_sign, 8'hFF, 23'd0} : {w_sign, 31'd0};
  // Ten bits keep the full range of Ea+Eb-BIAS so overflow/underflow are judged before packing
  assign w_exp      = {2'b00, w_ea} + {2'b00, w_eb} - 10'(BIAS);
  assign w_accept   = in_valid & in_ready;
  assign w_last     = r_cnt == CW'(MANT_W - 1);
  assign w_sum      = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign w_prod     = {r_acc, r_mplier};
  assign w_frac     = w_prod[2*MANT_W-1] ? w_prod[2*MANT_W-2 -: 23] : w_prod[2*MANT_W-3 -: 23];
  assign w_en       = r_exp + {9'd0, w_prod[2*MANT_W-1]};
  assign w_ovf      = w_en >= 10'sd255;
  assign w_unf      = w_en <= 10'sd0;
  assign w_norm_res = w_ovf ? {r_sign, 8'hFF, 23'd0} : w_unf ? {r_sign, 31'd0} : {r_sign, w_en[7:0], w_frac};
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_accept ? (w_special ? DONE : MULT) : IDLE)
           : r_state == MULT ? (w_last ? NORM : MULT)
           : r_state == NORM ? DONE
           : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_inv    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_accept) begin
        r_sign   <= w_sign;
        r_exp    <= w_exp;
        r_mcand  <= {1'b1, A[MANT_W-2:0]};
        r_mplier <= {1'b1, B[MANT_W-2:0]};
        r_acc    <= '0;
        r_cnt    <= '0;
        if (w_special) begin
          r_result <= w_spec_res;
          r_inv    <= w_inv;
        end
      end
      if (r_state == MULT) begin
        r_acc    <= w_sum[MANT_W:1];
        r_mplier <= {w_sum[0], r_mplier[MANT_W-1:1]};
        r_cnt    <= r_cnt + 1'b1;
      end
      if (r_state == NORM) begin
        r_result <= w_norm_res;
        r_ovf    <= w_ovf;
        r_unf    <= ~w_ovf & w_unf;
      end
      if (r_state == DONE && out_ready) begin
        r_result <= '0;
        r_ovf    <= 1'b0;
        r_unf    <= 1'b0;
        r_inv    <= 1'b0;
      end
    end
  end
  assign in_ready  = (r_state == IDLE) & ~rst;
  assign out_valid = r_state == DONE;
  assign busy      = r_state != IDLE;
  assign result    = r_result;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign invalid   = r_inv;
endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed binary32 multiply vectors checked against a behavioural model
module tb_fp_mul_seq;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic        in_ready, out_valid, overflow, underflow, invalid, busy;
  logic [31:0] result;
  int          n_checks = 0, n_fails = 0;
  logic [31:0] exp_res = '0;
  logic [2:0]  exp_flags = '0;
  bit          exp_pending = 1'b0;

  fp_mul_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow), .invalid(invalid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // {overflow, underflow, invalid, result}
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb, f;
    logic        s, za, zb, ia, ib, na, nb;
    logic [47:0] p;
    int          e;
    ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0]; s = a[31] ^ b[31];
    za = ea == 0; zb = eb == 0;
    ia = ea == 255 && fa == 0; ib = eb == 255 && fb == 0;
    na = ea == 255 && fa != 0; nb = eb == 255 && fb != 0;
    if (na || nb || (ia && zb) || (za && ib)) return {3'b001, 32'h7FC00000};
    if (ia || ib) return {3'b000, s, 8'hFF, 23'd0};
    if (za || zb) return {3'b000, s, 31'd0};
    p = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
    e = int'(ea) + int'(eb) - 127;
    if (p[47]) begin f = p[46:24]; e++; end
    else f = p[45:23];
    if (e >= 255) return {3'b100, s, 8'hFF, 23'd0};
    if (e <= 0) return {3'b010, s, 31'd0};
    return {3'b000, s, 8'(e), f};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!exp_pending) check("unexpected out_valid", 64'(out_valid), 64'd0);
      else begin
        check("result", 64'(result), 64'(exp_res));
        check("flags", 64'({overflow, underflow, invalid}), 64'(exp_flags));
      end
    end
  end

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lit_res, input logic [2:0] lit_flags,
                       input int lit_lat, input int hold);
    logic [34:0] m;
    int lat, w;
    m = model(a, b);
    check({tag, " model"}, 64'(m), {29'd0, lit_flags, lit_res});
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    check({tag, " in_ready before"}, 64'(in_ready), 64'd1);
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk);
    {exp_flags, exp_res} = m;
    exp_pending = 1'b1;
    #1 in_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 60);
    check({tag, " latency"}, 64'(lat), 64'(lit_lat));
    check({tag, " literal result"}, 64'(result), 64'(lit_res));
    check({tag, " literal flags"}, 64'({overflow, underflow, invalid}), 64'(lit_flags));
    for (int i = 0; i < hold; i++) begin
      A = 32'h3F800000; B = 32'h3F800000; in_valid = 1'b1;
      @(negedge clk);
      check({tag, " in_ready held"}, 64'(in_ready), 64'd0);
      check({tag, " out_valid held"}, 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    exp_pending = 1'b0;
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
    check({tag, " cleared"}, 64'({result, overflow, underflow, invalid}), 64'd0);
    check({tag, " in_ready after"}, 64'(in_ready), 64'd1);
    check({tag, " busy after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset outputs", 64'({out_valid, busy, result, overflow, underflow, invalid}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", 64'(in_ready), 64'd1);

    do_op("1.5x2",      32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 26, 0);
    do_op("1.5x1.5",    32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 26, 0);
    do_op("ovf",        32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100, 26, 0);
    do_op("ovf E=255",  32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100, 26, 0);
    do_op("unf",        32'h00800000, 32'h00800000, 32'h00000000, 3'b010, 26, 0);
    do_op("unf E=0",    32'h00800000, 32'h3F000000, 32'h00000000, 3'b010, 26, 0);
    do_op("unf neg",    32'h80800000, 32'h00800000, 32'h80000000, 3'b010, 26, 0);
    do_op("min normal", 32'h00800000, 32'h3F800000, 32'h00800000, 3'b000, 26, 0);
    do_op("-1x1",       32'hBF800000, 32'h3F800000, 32'hBF800000, 3'b000, 26, 0);
    do_op("inf x 0",    32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001, 1, 0);
    do_op("-inf x 2",   32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 1, 0);
    do_op("denorm",     32'h00000001, 32'h3F800000, 32'h00000000, 3'b000, 1, 0);
    do_op("nan",        32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b001, 1, 0);
    do_op("backpress",  32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 26, 10);

    A = 32'h3FC00000; B = 32'h40000000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid-op reset in_ready", 64'(in_ready), 64'd0);
    check("mid-op reset outputs", 64'({out_valid, busy, result, overflow, underflow, invalid}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid-op reset released", 64'({in_ready, busy}), 64'd2);
    do_op("after reset", 32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 26, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
